// File: rtl/nios_fft_frame_ctrl_if.sv
// nios_fft_frame_ctrl_if
//   Bundles the Avalon-MM slave port, the FFT streaming input and the level
//   interrupt of nios_fft_frame_ctrl.
//
//   address    [1:0]        Avalon word address
//   read                    Avalon read strobe
//   write                   Avalon write strobe
//   writedata  [31:0]       Avalon write data
//   readdata   [31:0]       Avalon read data, fixed latency 1
//   fft_valid               stream beat valid (no backpressure)
//   fft_sop                 first bin of frame, qualified by fft_valid
//   fft_eop                 last bin of frame, qualified by fft_valid
//   fft_data   [DATA_W-1:0] bin value
//   irq                     level interrupt
//
//   master: the CPU/interconnect plus FFT source side
//   slave : the frame controller
interface nios_fft_frame_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              fft_valid;
    logic              fft_sop;
    logic              fft_eop;
    logic [DATA_W-1:0] fft_data;
    logic              irq;

    modport master (
        output address, read, write, writedata,
        output fft_valid, fft_sop, fft_eop, fft_data,
        input  readdata, irq
    );

    modport slave (
        input  address, read, write, writedata,
        input  fft_valid, fft_sop, fft_eop, fft_data,
        output readdata, irq
    );
endinterface

// File: rtl/nios_fft_frame_ctrl.sv
// nios_fft_frame_ctrl
//   Captures one FFT output frame into a local bin buffer on CPU command and
//   exposes it to the Nios II through a 4-word Avalon-MM slave.
//
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of nios_fft_frame_ctrl_if (Avalon slave, FFT stream, irq)
//
//   Register map (word addresses):
//     0 CTRL    W: b0 start, b1 abort, b2 irq_en     R: irq_en in b2
//     1 STATUS  R: b0 busy, b1 done, b2 overflow, [31:16] bin_count
//               W: any value clears done and overflow
//     2 INDEX   R/W: read pointer
//     3 DATA    R: buf[rd_ptr], then rd_ptr increments (wraps)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no capture armed; waiting for start
//   WAIT_SOP | armed; discarding beats until a start-of-packet beat
//   CAPTURE  | storing beats; eop ends the frame, sop resyncs to bin 0
//   DONE     | frame complete; STATUS read/write returns to IDLE
module nios_fft_frame_ctrl #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input logic                   clk,
    input logic                   reset,
    nios_fft_frame_ctrl_if.slave  bus
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOP = 2'd1,
        S_CAPTURE  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [CNT_W-1:0]  bin_count, bin_count_nxt;
    logic              done, done_nxt;
    logic              overflow, overflow_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              irq_en;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ctrl_wr, stat_wr, stat_rd, idx_wr, data_rd;
    logic              cmd_start, cmd_abort, busy;
    logic [31:0]       status_word;
    logic              unused_wdata;

    // Register decode
    assign ctrl_wr   = bus.write && (bus.address == 2'd0);
    assign stat_wr   = bus.write && (bus.address == 2'd1);
    assign idx_wr    = bus.write && (bus.address == 2'd2);
    assign stat_rd   = bus.read  && (bus.address == 2'd1);
    assign data_rd   = bus.read  && (bus.address == 2'd3);
    assign cmd_start = ctrl_wr && bus.writedata[0];
    assign cmd_abort = ctrl_wr && bus.writedata[1];

    assign unused_wdata = ^bus.writedata[31:ADDR_W];

    assign busy        = (state == S_WAIT_SOP) || (state == S_CAPTURE);
    assign status_word = {16'(bin_count), 13'd0, overflow, done, busy};
    assign bus.irq     = done && irq_en;

    // Next-state and capture datapath
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        bin_count_nxt = bin_count;
        done_nxt      = done;
        overflow_nxt  = overflow;
        mem_we        = 1'b0;
        mem_waddr     = wr_ptr;

        if (stat_wr) begin
            done_nxt     = 1'b0;
            overflow_nxt = 1'b0;
        end

        if (cmd_abort) begin
            state_nxt    = S_IDLE;
            done_nxt     = 1'b0;
            overflow_nxt = 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (cmd_start) begin
                        state_nxt     = S_WAIT_SOP;
                        done_nxt      = 1'b0;
                        overflow_nxt  = 1'b0;
                        bin_count_nxt = '0;
                        wr_ptr_nxt    = '0;
                    end else if ((state == S_DONE) && (stat_rd || stat_wr)) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_WAIT_SOP: begin
                    if (bus.fft_valid && bus.fft_sop) begin
                        mem_we        = 1'b1;
                        mem_waddr     = '0;
                        wr_ptr_nxt    = ADDR_W'(1);
                        bin_count_nxt = CNT_W'(1);
                        if (bus.fft_eop) begin
                            state_nxt = S_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (bus.fft_valid) begin
                        if (bus.fft_sop) begin
                            // resync: a new sop restarts the frame at bin 0
                            mem_we        = 1'b1;
                            mem_waddr     = '0;
                            wr_ptr_nxt    = ADDR_W'(1);
                            bin_count_nxt = CNT_W'(1);
                        end else if (bin_count == CNT_W'(DEPTH)) begin
                            overflow_nxt = 1'b1;
                        end else begin
                            mem_we        = 1'b1;
                            mem_waddr     = wr_ptr;
                            wr_ptr_nxt    = wr_ptr + ADDR_W'(1);
                            bin_count_nxt = bin_count + CNT_W'(1);
                        end
                        if (bus.fft_eop) begin
                            state_nxt = S_DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            bin_count <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            bin_count <= bin_count_nxt;
            done      <= done_nxt;
            overflow  <= overflow_nxt;
        end
    end

    // Bin buffer write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= bus.fft_data;
        end
    end

    // CPU-side registers and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            irq_en       <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= bus.writedata[2];
            end

            if (idx_wr) begin
                rd_ptr <= bus.writedata[ADDR_W-1:0];
            end else if (data_rd) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end

            if (bus.read) begin
                unique case (bus.address)
                    2'd0:    bus.readdata <= {29'd0, irq_en, 2'b00};
                    2'd1:    bus.readdata <= status_word;
                    2'd2:    bus.readdata <= 32'(rd_ptr);
                    default: bus.readdata <= 32'(mem[rd_ptr]);
                endcase
            end
        end
    end

endmodule
